// File: rtl/timer_periph.sv
// timer_periph: bus-mapped reload timer with LED, switch and 7-seg registers; SYSTICK_EN adds a free-running cycle counter at 0x18
module timer_periph #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  switch,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irq
);
  logic [31:0] th, tl, pcnt, systick;
  logic [2:0]  tcon;
  logic [29:0] woff;
  logic [2:0]  idx;
  logic [7:0]  we;
  logic        hit, tick, ovf, ovf_set, unused_ok;
  assign unused_ok = ^addr[1:0];
  assign woff = addr[31:2] - BASE_ADDR[31:2];
  assign hit = woff[29:3] == '0;
  assign idx = woff[2:0];
  assign we = (wr && hit) ? 8'(1) << idx : '0;
  assign tick = tcon[0] && pcnt == 32'(PRESCALE - 1);
  assign ovf = tick && &tl;
  assign ovf_set = ovf && tcon[1];
  assign irq = tcon[1] & tcon[2];
  assign rdata = !(rd && hit) ? '0 :
                 idx == 3'd0 ? th :
                 idx == 3'd1 ? tl :
                 idx == 3'd2 ? {29'b0, tcon} :
                 idx == 3'd3 ? {24'b0, led} :
                 idx == 3'd4 ? {24'b0, switch} :
                 idx == 3'd5 ? {20'b0, digi} :
                 idx == 3'd6 ? systick : '0;
  always_ff @(posedge clk)
    if (reset) begin
      th <= '0;
      tl <= '0;
      tcon <= '0;
      pcnt <= '0;
      led <= '0;
      digi <= 12'hF00;
    end else begin
      if (tcon[0]) pcnt <= tick ? '0 : pcnt + 32'd1;
      if (tick) tl <= ovf ? th : tl + 32'd1;
      if (we[0]) th <= wdata;
      if (we[1]) begin
        tl <= wdata;
        pcnt <= '0;
      end
      // overflow status set beats a software clear landing on the same edge
      tcon <= we[2] ? {wdata[2] | ovf_set, wdata[1:0]} : {tcon[2] | ovf_set, tcon[1:0]};
      if (we[3]) led <= wdata[7:0];
      if (we[5]) digi <= wdata[11:0];
    end
`ifdef SYSTICK_EN
  always_ff @(posedge clk)
    systick <= reset ? '0 : systick + 32'd1;
`else
  assign systick = '0;
`endif
endmodule
